// File: rtl/router_pkt_tx_if.sv
// Packet-source handshake and router-side byte bus for router_pkt_tx.
// master = packet requester / router model, slave = router_pkt_tx.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       tx_done;
    logic       err_req;

    modport master (
        output start, dest_addr, payload_len, pl_data, pl_valid, busy,
        input  pl_ready, pkt_valid, data_out, tx_active, tx_done, err_req
    );

    modport slave (
        input  start, dest_addr, payload_len, pl_data, pl_valid, busy,
        output pl_ready, pkt_valid, data_out, tx_active, tx_done, err_req
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers a payload, then sends header, payload and parity bytes to the router
// honouring busy stalls, followed by a fixed idle gap.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input logic             clock,
    input logic             resetn,
    router_pkt_tx_if.slave  bus
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t          state;
    logic [1:0]      addr_q;
    logic [5:0]      len_q;
    logic [5:0]      wr_cnt;
    logic [5:0]      rd_cnt;
    logic [5:0]      rd_nxt;
    logic [7:0]      parity;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      mem [0:62];

    logic            pkt_valid_q;
    logic [7:0]      data_out_q;
    logic            pl_ready_q;
    logic            tx_active_q;
    logic            tx_done_q;
    logic            err_req_q;

    assign rd_nxt = rd_cnt + 6'd1;

    // Outputs are registered alongside the state, so each transition also
    // loads the values the next state presents on the bus.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            parity      <= '0;
            gap_cnt     <= '0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= '0;
            pl_ready_q  <= 1'b0;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
            err_req_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            err_req_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.payload_len == '0 || bus.dest_addr == 2'd3) begin
                            err_req_q <= 1'b1;
                        end else begin
                            addr_q      <= bus.dest_addr;
                            len_q       <= bus.payload_len;
                            parity      <= {bus.payload_len, bus.dest_addr};
                            wr_cnt      <= '0;
                            rd_cnt      <= '0;
                            gap_cnt     <= '0;
                            pl_ready_q  <= 1'b1;
                            tx_active_q <= 1'b1;
                            state       <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (bus.pl_valid) begin
                        mem[wr_cnt] <= bus.pl_data;
                        parity      <= parity ^ bus.pl_data;
                        wr_cnt      <= wr_cnt + 6'd1;
                        if (wr_cnt == len_q - 6'd1) begin
                            pl_ready_q  <= 1'b0;
                            pkt_valid_q <= 1'b1;
                            data_out_q  <= {len_q, addr_q};
                            state       <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (!bus.busy) begin
                        rd_cnt     <= '0;
                        data_out_q <= mem[0];
                        state      <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!bus.busy) begin
                        rd_cnt <= rd_nxt;
                        if (rd_cnt == len_q - 6'd1) begin
                            pkt_valid_q <= 1'b0;
                            data_out_q  <= parity;
                            state       <= PARITY;
                        end else begin
                            data_out_q <= mem[rd_nxt];
                        end
                    end
                end
                PARITY: begin
                    if (!bus.busy) begin
                        data_out_q <= '0;
                        gap_cnt    <= '0;
                        tx_done_q  <= (GAP_CYCLES == 1);
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        tx_active_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        // Pulse lands on the final gap cycle, one step ahead.
                        if (gap_cnt == GW'(GAP_CYCLES - 2))
                            tx_done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pkt_valid = pkt_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.pl_ready  = pl_ready_q;
    assign bus.tx_active = tx_active_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.err_req   = err_req_q;
endmodule
